// File: rtl/act_sched_pkg.sv
// ---------------------------------------------------------------------------
// act_sched_pkg
// Shared constants for the activation-unit scheduler: default operand width,
// the activation unit's fixed latency, the requester-tag width helper and the
// leaky-ReLU slope constants used by the activation instance.
// ---------------------------------------------------------------------------
package act_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ACT_LATENCY    = 7;

  // fp32 slopes of the shared leaky-ReLU instance
  localparam logic [31:0] LRELU_NEG_SLOPE = 32'h3E80_0000;  // 0.25
  localparam logic [31:0] LRELU_POS_SLOPE = 32'h3F00_0000;  // 0.5

  // Bits needed to name one of n requesters (at least 1).
  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// ---------------------------------------------------------------------------
// act_rr_arbiter
// Round-robin arbiter. The grant goes to the first requester with req=1,
// searching upward from the pointer with wrap-around. When advance is high
// the pointer moves to one past the granted requester; otherwise it holds.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (pointer -> 0)
//   req      in   [N-1:0] request vector
//   advance  in   grant was taken this cycle
//   grant    out  [N-1:0] one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module act_rr_arbiter
  import act_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = tag_width(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] gidx;
  logic          found;
  int            pos;

  always_comb begin
    grant = '0;
    gidx  = '0;
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    for (int j = 0; j < N; j++) begin
      pos = int'(ptr) + j;
      if (pos >= N) pos = pos - N;
      sel = PW'(pos);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        gidx       = sel;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/act_unit_scheduler.sv
// ---------------------------------------------------------------------------
// act_unit_scheduler
// Shares one fixed-latency fp32 leaky-ReLU unit between NUM_REQ requesters.
// A round-robin arbiter picks at most one operand per cycle, the operand is
// registered toward the unit, and a tag pipeline travelling beside it steers
// the unit's result back to the issuing requester (1+LATENCY clocks later).
//
// Optional feature (macro ACT_SCHED_TAG_CHECK_EN): adds o_err, a sticky flag
// raised when the unit's valid-out disagrees with the tag pipeline.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req_valid      [NUM_REQ]             per-requester operand valid
//   i_req_data       [NUM_REQ*DATA_WIDTH]  packed operands
//   o_req_ready      [NUM_REQ]             one-hot grant
//   o_act_valid/data                       operand to activation unit
//   i_act_valid/data                       result from activation unit
//   o_rsp_valid      [NUM_REQ]             one-hot result strobe
//   o_rsp_data       [DATA_WIDTH]          result, common to all requesters
//   o_busy                                 operation in flight
//   o_err            (optional)            sticky tag/valid mismatch
// ---------------------------------------------------------------------------
module act_unit_scheduler
  import act_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = ACT_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_act_valid,
  output logic [DATA_WIDTH-1:0]         o_act_data,
  input  logic                          i_act_valid,
  input  logic [DATA_WIDTH-1:0]         i_act_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_busy
`ifdef ACT_SCHED_TAG_CHECK_EN
  ,
  output logic                          o_err
`endif
);

  localparam int TW = tag_width(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 2);

  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [TW-1:0]         grant_tag;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [TW-1:0]         tag_issue;
  logic                  tag_vld_p [LATENCY];
  logic [TW-1:0]         tag_p     [LATENCY];
  logic                  tag_vld_out;
  logic [TW-1:0]         tag_out;
  logic                  rsp_fire;
  logic [CW-1:0]         inflight;

  // Grants only ever go to valid requesters, so any grant is an accept.
  act_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (i_req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign o_req_ready = grant;
  assign accept      = |grant;

  always_comb begin
    grant_tag  = '0;
    grant_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        grant_tag  = TW'(k);
        grant_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---- issue stage: operand and its tag registered toward the unit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_act_valid <= 1'b0;
      o_act_data  <= '0;
      tag_issue   <= '0;
    end else begin
      o_act_valid <= accept;
      if (accept) begin
        o_act_data <= grant_data;
        tag_issue  <= grant_tag;
      end
    end
  end

  // ---- tag pipeline: LATENCY stages, last stage meets the unit's valid-out ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_p[s]     <= '0;
      end
    end else begin
      tag_vld_p[0] <= o_act_valid;
      tag_p[0]     <= tag_issue;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_p[s]     <= tag_p[s-1];
      end
    end
  end

  assign tag_vld_out = tag_vld_p[LATENCY-1];
  assign tag_out     = tag_p[LATENCY-1];

  // ---- response: strobe only when the unit and the tag pipeline agree ----
  assign rsp_fire   = i_act_valid & tag_vld_out;
  assign o_rsp_data = i_act_data;

  always_comb begin
    o_rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_rsp_valid[k] = rsp_fire && (tag_out == TW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign o_busy = (inflight != '0);

`ifdef ACT_SCHED_TAG_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (i_act_valid != tag_vld_out) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_act_unit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_act_unit_scheduler
// Bench for act_unit_scheduler with NUM_REQ=4, LATENCY=7. Contains a
// stand-in 7-clock leaky-ReLU unit (exponent shift, normal operands only)
// and a cycle-indexed reference model of arbitration and result return.
// ---------------------------------------------------------------------------
module tb_act_unit_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 7;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             act_valid;
  logic [W-1:0]     act_data;
  logic             unit_valid;
  logic [W-1:0]     unit_data;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy;
  logic             force_stray;
`ifdef ACT_SCHED_TAG_CHECK_EN
  logic             err;
`endif

  int total = 0;
  int bad   = 0;

  act_unit_scheduler #(.DATA_WIDTH(W), .NUM_REQ(N), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_act_valid (act_valid),
    .o_act_data  (act_data),
    .i_act_valid (unit_valid),
    .i_act_data  (unit_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_busy      (busy)
`ifdef ACT_SCHED_TAG_CHECK_EN
    ,
    .o_err       (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Leaky ReLU on normal fp32: x*0.5 for x>=0, x*0.25 for x<0.
  function automatic logic [31:0] leaky(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y[30:23] = x[31] ? x[30:23] - 8'd2 : x[30:23] - 8'd1;
    return y;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(8, 250));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // ---- stand-in activation unit: 7-clock pipe, shares rst_n ----
  logic        uv [LAT];
  logic [31:0] ud [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        uv[i] <= 1'b0;
        ud[i] <= '0;
      end
    end else begin
      uv[0] <= act_valid;
      ud[0] <= leaky(act_data);
      for (int i = 1; i < LAT; i++) begin
        uv[i] <= uv[i-1];
        ud[i] <= ud[i-1];
      end
    end
  end
  assign unit_valid = uv[LAT-1] | force_stray;
  assign unit_data  = ud[LAT-1];

  // ---- reference model: round-robin choice and a ring of due results ----
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int j = 0; j < N; j++) begin
      if (v[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  int          model_ptr;
  int          cyc;
  int          exp_idx;
  bit          ring_v [16];
  int          ring_k [16];
  logic [31:0] ring_d [16];

  always_comb exp_idx = pick(model_ptr, req_valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_ptr <= 0;
      cyc       <= 0;
      for (int i = 0; i < 16; i++) ring_v[i] <= 1'b0;
    end else begin
      ring_v[cyc % 16] <= 1'b0;
      if (exp_idx >= 0) begin
        ring_v[(cyc + 1 + LAT) % 16] <= 1'b1;
        ring_k[(cyc + 1 + LAT) % 16] <= exp_idx;
        ring_d[(cyc + 1 + LAT) % 16] <= leaky(req_data[exp_idx*W +: W]);
        model_ptr <= (exp_idx + 1) % N;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    force_stray = 1'b0;
    @(negedge clk);
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL reset_act_valid got %b want 0", act_valid); end
    total++; if (act_data !== 32'h0) begin bad++; $display("FAIL reset_act_data got %h want 0", act_data); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_idle got %b want 0000", req_ready); end
`ifdef ACT_SCHED_TAG_CHECK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
`endif
    #1 req_valid = 4'b1111;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_ready_ptr0 got %b want 0001", req_ready); end
    #1 req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input int k, input logic [31:0] din,
                             input logic [3:0] ev, input logic [31:0] ed);
    req_data[k*W +: W] = din;
    req_valid = 4'(1 << k);
    @(negedge clk);
    total++; if (req_ready !== ev) begin bad++; $display("FAIL single%0d_grant got %b want %b", k, req_ready, ev); end
    tick();
    req_valid = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) begin
        total++; if (rsp_valid !== ev) begin bad++; $display("FAIL single%0d_rsp_valid got %b want %b", k, rsp_valid, ev); end
        total++; if (rsp_data !== ed) begin bad++; $display("FAIL single%0d_rsp_data got %h want %h", k, rsp_data, ed); end
      end else begin
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single%0d_quiet c%0d got %b want 0000", k, i, rsp_valid); end
      end
      total++; if (busy !== (i <= 8)) begin bad++; $display("FAIL single%0d_busy c%0d got %b want %b", k, i, busy, (i <= 8)); end
      tick();
    end
  endtask

  task automatic test_full_throughput();
    logic [31:0] d [N];
    apply_reset();
    for (int k = 0; k < N; k++) begin
      d[k] = rand_op();
      req_data[k*W +: W] = d[k];
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'(1 << (i % N))) begin bad++; $display("FAIL full_grant c%0d got %b want %b", i, req_ready, 4'(1 << (i % N))); end
      total++; if (busy !== (i > 0)) begin bad++; $display("FAIL full_busy_issue c%0d got %b want %b", i, busy, (i > 0)); end
      tick();
    end
    req_valid = '0;
    for (int i = 8; i <= 16; i++) begin
      @(negedge clk);
      if (i <= 15) begin
        total++; if (rsp_valid !== 4'(1 << ((i - 8) % N))) begin bad++; $display("FAIL full_rsp_valid c%0d got %b want %b", i, rsp_valid, 4'(1 << ((i - 8) % N))); end
        total++; if (rsp_data !== leaky(d[(i - 8) % N])) begin bad++; $display("FAIL full_rsp_data c%0d got %h want %h", i, rsp_data, leaky(d[(i - 8) % N])); end
      end else begin
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL full_rsp_end got %b want 0000", rsp_valid); end
      end
      total++; if (busy !== (i <= 15)) begin bad++; $display("FAIL full_busy c%0d got %b want %b", i, busy, (i <= 15)); end
      tick();
    end
  endtask

  task automatic test_pointer_wrap();
    apply_reset();
    req_data  = {rand_op(), rand_op(), rand_op(), rand_op()};
    req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_setup got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_first got %b want 1000", req_ready); end
    tick();
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_second got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ptr_end got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_data  = {rand_op(), rand_op(), rand_op(), rand_op()};
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_in_reset got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL midrst_rsp c%0d got %b want 0000", i, rsp_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy c%0d got %b want 0", i, busy); end
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_ptr got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    logic [3:0]  ev;
    logic        eb;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        req_valid = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
        for (int k = 0; k < N; k++) req_data[k*W +: W] = rand_op();
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      ev = (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx);
      total++; if (req_ready !== ev) begin bad++; $display("FAIL rand_grant c%0d got %b want %b", c, req_ready, ev); end
      ev = ring_v[cyc % 16] ? 4'(1 << ring_k[cyc % 16]) : 4'b0000;
      total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rand_rsp_valid c%0d got %b want %b", c, rsp_valid, ev); end
      if (ring_v[cyc % 16]) begin
        total++; if (rsp_data !== ring_d[cyc % 16]) begin bad++; $display("FAIL rand_rsp_data c%0d got %h want %h", c, rsp_data, ring_d[cyc % 16]); end
      end
      eb = 1'b0;
      for (int j = 0; j <= LAT; j++) eb = eb | ring_v[(cyc + j) % 16];
      total++; if (busy !== eb) begin bad++; $display("FAIL rand_busy c%0d got %b want %b", c, busy, eb); end
      tick();
    end
  endtask

  task automatic test_stray();
`ifdef ACT_SCHED_TAG_CHECK_EN
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL stray_err_before got %b want 0", err); end
    tick();
`endif
    force_stray = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL stray_rsp got %b want 0000", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_busy got %b want 0", busy); end
    tick();
    force_stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL stray_rsp_after c%0d got %b want 0000", i, rsp_valid); end
`ifdef ACT_SCHED_TAG_CHECK_EN
      total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_err_sticky c%0d got %b want 1", i, err); end
`endif
      tick();
    end
`ifdef ACT_SCHED_TAG_CHECK_EN
    apply_reset();
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL stray_err_cleared got %b want 0", err); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single(1, 32'h4000_0000, 4'b0010, 32'h3F80_0000);
    test_single(2, 32'hC080_0000, 4'b0100, 32'hBF80_0000);
    test_full_throughput();
    test_pointer_wrap();
    test_reset_mid();
    test_random();
    test_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
